// File: rtl/mips_pc_pkg.sv
// Shared types, default vectors and redirect-priority helper for the fetch-side PC sequencer.
package mips_pc_pkg;

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} pc_state_t;

  typedef enum logic [1:0] {REDIR_NONE, REDIR_BRANCH, REDIR_JUMP, REDIR_EXC} redir_t;

  localparam int          DEFAULT_INSTR_BYTES  = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

  function automatic redir_t redirect_sel(input logic exception, input logic jump,
                                          input logic branch_taken);
    if (exception)         return REDIR_EXC;
    else if (jump)         return REDIR_JUMP;
    else if (branch_taken) return REDIR_BRANCH;
    else                   return REDIR_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Priority select of redirect target, sequential pc_plus4 or hold; target also feeds the pending latch.
// Optional PC_MISALIGN_TRAP_EN: misaligned jump/branch targets are replaced by EXC_VECTOR.
module next_pc_mux
  import mips_pc_pkg::*;
#(
  parameter int                      ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] EXC_VECTOR   = ADDRESS_SIZE'(DEFAULT_EXC_VECTOR),
  parameter int                      INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic                    exception,
  input  logic                    jump,
  input  logic                    branch_taken,
  input  logic [ADDRESS_SIZE-1:0] jump_target,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  input  logic [ADDRESS_SIZE-1:0] pc,
  input  logic [ADDRESS_SIZE-1:0] pc_plus4,
  input  logic                    advance,
  output logic                    redirect,
  output logic [ADDRESS_SIZE-1:0] target,
  output logic [ADDRESS_SIZE-1:0] next_pc
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                    misaligned
`endif
);

  localparam logic [ADDRESS_SIZE-1:0] LOW_MASK = ADDRESS_SIZE'(INSTR_BYTES - 1);

  redir_t                  sel;
  logic [ADDRESS_SIZE-1:0] raw;

  always_comb begin
    sel = redirect_sel(exception, jump, branch_taken);
    raw = pc;
    case (sel)
      REDIR_EXC:    raw = EXC_VECTOR;
      REDIR_JUMP:   raw = jump_target;
      REDIR_BRANCH: raw = branch_target;
      default:      raw = pc;
    endcase
  end

  assign redirect = (sel != REDIR_NONE);

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = ((sel == REDIR_JUMP) || (sel == REDIR_BRANCH)) && (|(raw & LOW_MASK));
  assign target     = misaligned ? (EXC_VECTOR & ~LOW_MASK) : (raw & ~LOW_MASK);
`else
  assign target     = raw & ~LOW_MASK;
`endif

  assign next_pc = redirect ? target : (advance ? pc_plus4 : pc);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: sequences the PC against a ready/request imem port and drains redirected fetches.
// Optional PC_MISALIGN_TRAP_EN adds misalign_err and traps misaligned jump/branch targets.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                      ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR = ADDRESS_SIZE'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDRESS_SIZE-1:0] EXC_VECTOR   = ADDRESS_SIZE'(DEFAULT_EXC_VECTOR),
  parameter int                      INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    exception,
  input  logic                    jump,
  input  logic [ADDRESS_SIZE-1:0] jump_target,
  input  logic                    branch_taken,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  output logic                    imem_req,
  output logic [ADDRESS_SIZE-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic [31:0]             imem_rdata,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic [ADDRESS_SIZE-1:0] pc,
  output logic [ADDRESS_SIZE-1:0] pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                    misalign_err
`endif
);

  pc_state_t               state;
  logic [ADDRESS_SIZE-1:0] pending;
  logic [ADDRESS_SIZE-1:0] target;
  logic [ADDRESS_SIZE-1:0] next_pc;
  logic                    redirect;
  logic                    advance;
`ifdef PC_MISALIGN_TRAP_EN
  logic                    misaligned;
`endif

  // pc stays on the outstanding address during DRAIN, so it doubles as the fetch address
  assign pc_plus4  = pc + ADDRESS_SIZE'(INSTR_BYTES);
  assign imem_addr = pc;
  assign imem_req  = (state == DRAIN) || ((state == FETCH) && !stall);
  assign advance   = imem_ready && !stall;

  next_pc_mux #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .EXC_VECTOR   (EXC_VECTOR),
    .INSTR_BYTES  (INSTR_BYTES)
  ) u_next_pc_mux (
    .exception     (exception),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .advance       (advance),
    .redirect      (redirect),
    .target        (target),
    .next_pc       (next_pc)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pending     <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          // a redirect against an unanswered request must let that request complete first
          if (redirect && imem_req && !imem_ready) begin
            pending <= target;
            state   <= DRAIN;
          end else begin
            pc <= next_pc;
          end
          if (advance && !redirect) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end
`ifdef PC_MISALIGN_TRAP_EN
          misalign_err <= misaligned;
`endif
        end
        DRAIN: begin
          if (redirect) pending <= target;
          if (imem_ready) begin
            pc    <= redirect ? target : pending;
            state <= FETCH;
          end
`ifdef PC_MISALIGN_TRAP_EN
          misalign_err <= misaligned;
`endif
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: rule-level model plus per-cycle compare and literal spot checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        exception = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  // Instruction memory contents are a fixed function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: what the fetch side must present, derived from the redirect/stall/ready rules
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_waiting;
  logic [31:0] m_dest;
  logic        m_valid;
  logic [31:0] m_instr;
  logic        m_mis;

  always @(posedge clk or posedge reset) begin
    logic        redir;
    logic [31:0] tgt;
    logic        bad;
    if (reset) begin
      m_pc = 32'h0; m_boot = 1'b1; m_waiting = 1'b0; m_dest = 32'h0;
      m_valid = 1'b0; m_instr = 32'h0; m_mis = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_mis   = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        redir = exception | jump | branch_taken;
        tgt   = exception ? 32'h80 : (jump ? jump_target : branch_target);
        bad   = !exception && redir && (tgt[1:0] != 2'b00);
`ifdef PC_MISALIGN_TRAP_EN
        if (bad) tgt = 32'h80;
        m_mis = bad;
`endif
        tgt[1:0] = 2'b00;
        if (m_waiting) begin
          if (redir) m_dest = tgt;
          if (imem_ready) begin
            m_pc = m_dest;
            m_waiting = 1'b0;
          end
        end else if (redir) begin
          if (!stall && !imem_ready) begin
            m_waiting = 1'b1;
            m_dest    = tgt;
          end else begin
            m_pc = tgt;
          end
        end else if (!stall && imem_ready) begin
          m_valid = 1'b1;
          m_instr = mem_word(m_pc);
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("imem_req", {31'b0, imem_req}, {31'b0, m_waiting | (!m_boot & !stall)});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    if (m_valid) check("instr", instr, m_instr);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    reset = 1'b0;

    tick(); check("seq_addr0", imem_addr, 32'h0);
    tick(); check("seq_addr4", imem_addr, 32'h4);
    check("seq_valid0", {31'b0, instr_valid}, 32'h1);
    check("seq_instr0", instr, mem_word(32'h0));
    tick(); check("seq_addr8", imem_addr, 32'h8);

    jump = 1'b1; jump_target = 32'h100;
    tick(); check("jmp_addr", imem_addr, 32'h100);
    check("jmp_drop", {31'b0, instr_valid}, 32'h0);
    jump = 1'b0;
    tick(); check("jmp_instr", instr, mem_word(32'h100));

    imem_ready = 1'b0;
    tick(); check("nordy_hold", pc, 32'h104);
    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); check("drain_addr", imem_addr, 32'h104);
    check("drain_req", {31'b0, imem_req}, 32'h1);
    branch_taken = 1'b0;
    tick(); check("drain_hold", imem_addr, 32'h104);
    imem_ready = 1'b1;
    tick(); check("drain_done", imem_addr, 32'h40);
    check("drain_drop", {31'b0, instr_valid}, 32'h0);
    tick(); check("br_instr", instr, mem_word(32'h40));

    exception = 1'b1; jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    tick(); check("prio_exc", pc, 32'h80);
    exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tick();

    jump = 1'b1; jump_target = 32'h10;
    tick(); jump = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h10);
      check("stall_req", {31'b0, imem_req}, 32'h0);
      check("stall_valid", {31'b0, instr_valid}, 32'h0);
    end
    stall = 1'b0;
    tick(); check("resume_pc", pc, 32'h14);
    check("resume_instr", instr, mem_word(32'h10));

    stall = 1'b1; jump = 1'b1; jump_target = 32'h20;
    tick(); check("stall_redir", pc, 32'h20);
    stall = 1'b0; jump = 1'b0;
    tick(); check("stall_redir_next", pc, 32'h24);

    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); check("wrap_pc4", pc_plus4, 32'h0);
    jump = 1'b0;
    tick(); check("wrap_pc", pc, 32'h0);

    jump = 1'b1; jump_target = 32'h103;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_trap", pc, 32'h80);
`else
    check("mis_align", pc, 32'h100);
`endif
    jump = 1'b0;
    tick();

    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick(); branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h300;
    tick(); jump = 1'b0; imem_ready = 1'b1;
    tick(); check("last_wins", pc, 32'h300);
    tick(); check("last_wins_instr", instr, mem_word(32'h300));

    imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h500;
    tick(); jump = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    check("rst_drain_pc", pc, 32'h0);
    check("rst_drain_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_drain_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b0;
    imem_ready = 1'b1;
    tick(); check("reboot_addr", imem_addr, 32'h0);
    tick(); check("reboot_instr", instr, mem_word(32'h0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
